// File: rtl/rv32_scoreboard.sv
// ----------------------------------------------------------------------------
// rv32_scoreboard
//   Register scoreboard between rv32 decode and execute. Each architectural
//   register x1..x31 has a counter of in-flight writes. Decode is stalled
//   while it reads a register with outstanding writes. It is also stalled
//   when issuing would overflow the destination counter.
//
//   Optional feature (macro RV32_SB_BYPASS_EN):
//     When defined, execute forwarding is assumed. A second table counts
//     in-flight loads, and only load-use dependencies stall. When undefined,
//     the block is a full interlock and the load inputs are ignored.
//
// Ports
//   clk            core clock
//   resetn         asynchronous active-low reset
//   id_valid       decode holds a valid instruction
//   id_rs1/id_rs2  source registers
//   id_use_rs      [0] reads rs1, [1] reads rs2
//   id_rd          destination register
//   id_register_wb instruction writes rd
//   id_is_load     rd comes from memory data
//   id_stall       hold decode this cycle (combinational from registered counts)
//   id_issue       id_valid & ~id_stall
//   ret_valid      writeback retires a tracked instruction
//   ret_rd         rd of the retiring instruction
//   ret_is_load    retiring instruction was a load
//   busy           any counter non-zero (registered)
//   err_underflow  sticky: retire seen for a register whose count was 0
// ----------------------------------------------------------------------------
module rv32_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [1:0] id_use_rs,
    input  logic [4:0] id_rd,
    input  logic       id_register_wb,
    input  logic       id_is_load,
    output logic       id_stall,
    output logic       id_issue,
    input  logic       ret_valid,
    input  logic [4:0] ret_rd,
    input  logic       ret_is_load,
    output logic       busy,
    output logic       err_underflow
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Increment or decrement one counter. A simultaneous inc and dec cancel out.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic inc,
                                                  input logic dec);
        logic [CNT_W-1:0] res;
        if (inc && !dec) begin
            res = cur + CNT_ONE;
        end else if (dec && !inc) begin
            res = cur - CNT_ONE;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // Entry 0 stays zero forever, so x0 never hazards and never overflows.
    logic [CNT_W-1:0] wr_cnt_r   [32];
    logic [CNT_W-1:0] wr_cnt_nxt_s [32];
    logic             busy_r;
    logic             err_underflow_r;

    logic             ret_live_s;
    logic             ret_same_rd_s;
    logic             wr_inc_s;
    logic             wr_dec_s;
    logic             hazard_rs1_s;
    logic             hazard_rs2_s;
    logic             structural_s;
    logic             underflow_s;
    logic             busy_nxt_s;

    assign ret_live_s    = ret_valid & (ret_rd != 5'd0);
    assign ret_same_rd_s = ret_valid & (ret_rd == id_rd);
    assign wr_inc_s      = id_issue & id_register_wb & (id_rd != 5'd0);
    assign wr_dec_s      = ret_live_s & (wr_cnt_r[ret_rd] != CNT_ZERO);

`ifdef RV32_SB_BYPASS_EN
    logic [CNT_W-1:0] ld_cnt_r   [32];
    logic [CNT_W-1:0] ld_cnt_nxt_s [32];
    logic             ld_inc_s;
    logic             ld_dec_s;

    assign ld_inc_s = wr_inc_s & id_is_load;
    assign ld_dec_s = ret_live_s & ret_is_load & (ld_cnt_r[ret_rd] != CNT_ZERO);

    // Only pending loads create a read hazard; ALU results are forwarded.
    assign hazard_rs1_s = id_use_rs[0] & (id_rs1 != 5'd0) & (ld_cnt_r[id_rs1] != CNT_ZERO);
    assign hazard_rs2_s = id_use_rs[1] & (id_rs2 != 5'd0) & (ld_cnt_r[id_rs2] != CNT_ZERO);

    // Either table full blocks issue unless the same rd retires this cycle.
    assign structural_s = id_register_wb & ~ret_same_rd_s &
                          ((wr_cnt_r[id_rd] == CNT_MAX) |
                           (id_is_load & (ld_cnt_r[id_rd] == CNT_MAX)));

    assign underflow_s = ret_live_s & ((wr_cnt_r[ret_rd] == CNT_ZERO) |
                                       (ret_is_load & (ld_cnt_r[ret_rd] == CNT_ZERO)));
`else
    logic unused_load_s;
    assign unused_load_s = id_is_load ^ ret_is_load;

    assign hazard_rs1_s = id_use_rs[0] & (id_rs1 != 5'd0) & (wr_cnt_r[id_rs1] != CNT_ZERO);
    assign hazard_rs2_s = id_use_rs[1] & (id_rs2 != 5'd0) & (wr_cnt_r[id_rs2] != CNT_ZERO);

    // A full counter blocks issue unless the same rd retires this cycle.
    assign structural_s = id_register_wb & ~ret_same_rd_s & (wr_cnt_r[id_rd] == CNT_MAX);

    assign underflow_s = ret_live_s & (wr_cnt_r[ret_rd] == CNT_ZERO);
`endif

    // The stall uses registered counts only; a same-cycle retire of a source does not help.
    assign id_stall = id_valid & (hazard_rs1_s | hazard_rs2_s | structural_s);
    assign id_issue = id_valid & ~id_stall;

    assign busy          = busy_r;
    assign err_underflow = err_underflow_r;

    // Next-state counters and the busy flag derived from them.
    always_comb begin
        busy_nxt_s      = 1'b0;
        wr_cnt_nxt_s[0] = CNT_ZERO;
`ifdef RV32_SB_BYPASS_EN
        ld_cnt_nxt_s[0] = CNT_ZERO;
`endif
        for (int i = 1; i < 32; i++) begin
            wr_cnt_nxt_s[i] = cnt_next(wr_cnt_r[i],
                                       wr_inc_s & (id_rd == 5'(i)),
                                       wr_dec_s & (ret_rd == 5'(i)));
`ifdef RV32_SB_BYPASS_EN
            ld_cnt_nxt_s[i] = cnt_next(ld_cnt_r[i],
                                       ld_inc_s & (id_rd == 5'(i)),
                                       ld_dec_s & (ret_rd == 5'(i)));
`endif
            if (wr_cnt_nxt_s[i] != CNT_ZERO) begin
                busy_nxt_s = 1'b1;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
    end

    // Counter tables, busy and sticky underflow error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                wr_cnt_r[i] <= CNT_ZERO;
`ifdef RV32_SB_BYPASS_EN
                ld_cnt_r[i] <= CNT_ZERO;
`endif
            end
            busy_r          <= 1'b0;
            err_underflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                wr_cnt_r[i] <= wr_cnt_nxt_s[i];
`ifdef RV32_SB_BYPASS_EN
                ld_cnt_r[i] <= ld_cnt_nxt_s[i];
`endif
            end
            busy_r          <= busy_nxt_s;
            err_underflow_r <= err_underflow_r | underflow_s;
        end
    end

endmodule
